// File: rtl/alu_mul_sequencer_pkg.sv
// Shared definitions for the execute-stage ALU and the shift-add multiply sequencer.
package alu_mul_sequencer_pkg;

    // ALU control encodings; bit 3 selects inversion of b with carry-in for subtract.
    localparam logic [3:0] ALU_CTL_ADD = 4'b0000;
    localparam logic [3:0] ALU_CTL_AND = 4'b0001;
    localparam logic [3:0] ALU_CTL_OR  = 4'b0010;
    localparam logic [3:0] ALU_CTL_XOR = 4'b0011;
    localparam logic [3:0] ALU_CTL_SUB = 4'b1000;

    // Bit positions inside the ALU flag vector {v,c,n,z}.
    localparam int FLAG_V = 3;
    localparam int FLAG_C = 2;
    localparam int FLAG_N = 1;
    localparam int FLAG_Z = 0;

    // Multiply sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } mul_state_t;

endpackage

// File: rtl/alu_mul_sequencer.sv
// Unsigned WIDTH x WIDTH -> 2*WIDTH shift-add multiplier that borrows the shared
// ALU adder for WIDTH iterations, then hands it back to the datapath.
module alu_mul_sequencer
    import alu_mul_sequencer_pkg::*;
#(
    parameter int         WIDTH   = 32,
    parameter int         CNT_W   = 5,
    parameter logic [3:0] ALU_ADD = ALU_CTL_ADD
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi,
    output logic             alu_sel,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_control,
    input  logic [WIDTH-1:0] alu_result,
    input  logic [3:0]       alu_flags
);

    mul_state_t       r_state;
    mul_state_t       w_state_nxt;
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_acc_hi;
    logic [WIDTH-1:0] r_acc_lo;
    logic [CNT_W-1:0] r_cnt;

    logic             w_accept;
    logic             w_last;
    logic             w_carry;
    logic [WIDTH-1:0] w_acc_hi_step;
    logic [WIDTH-1:0] w_acc_lo_step;
    logic [2:0]       w_unused_flags;

    // Only the carry flag matters; the rest of the ALU flags are deliberately ignored.
    assign w_unused_flags = {alu_flags[FLAG_V], alu_flags[FLAG_N], alu_flags[FLAG_Z]};

    // A new operation may be taken from IDLE or straight out of DONE.
    assign w_accept = start && (r_state == ST_IDLE || r_state == ST_DONE);
    assign w_last   = (r_cnt == CNT_W'(WIDTH - 1));

    // ALU is always driven with acc_hi + (multiplier bit ? mcand : 0); the core
    // only looks at it while alu_sel is high.
    assign alu_a       = r_acc_hi;
    assign alu_b       = r_acc_lo[0] ? r_mcand : '0;
    assign alu_control = ALU_ADD;

    // Adding zero can never carry, so mask the flag to avoid trusting a stale carry.
    assign w_carry       = alu_flags[FLAG_C] & r_acc_lo[0];
    assign w_acc_hi_step = {w_carry, alu_result[WIDTH-1:1]};
    assign w_acc_lo_step = {alu_result[0], r_acc_lo[WIDTH-1:1]};

    // Status decoded purely from registered state, so no input-to-output glitches.
    assign busy      = (r_state == ST_RUN);
    assign alu_sel   = busy;
    assign done      = (r_state == ST_DONE);
    assign result_lo = r_acc_lo;
    assign result_hi = r_acc_hi;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next-state logic: DONE lasts one cycle unless a new start chains into RUN.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (start) w_state_nxt = ST_RUN;
            ST_RUN:  if (w_last) w_state_nxt = ST_DONE;
            ST_DONE: w_state_nxt = start ? ST_RUN : ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Operand capture and one shift-add step per RUN cycle; values hold otherwise
    // so the product stays visible after DONE.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mcand  <= '0;
            r_acc_hi <= '0;
            r_acc_lo <= '0;
            r_cnt    <= '0;
        end else if (w_accept) begin
            r_mcand  <= op_a;
            r_acc_hi <= '0;
            r_acc_lo <= op_b;
            r_cnt    <= '0;
        end else if (r_state == ST_RUN) begin
            r_acc_hi <= w_acc_hi_step;
            r_acc_lo <= w_acc_lo_step;
            r_cnt    <= r_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Bench for alu_mul_sequencer wired to a behavioural ALU; products are checked
// against plain 64-bit multiplication and timing against the documented latency.
module tb_alu_mul_sequencer;
    import alu_mul_sequencer_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [W-1:0] op_a, op_b;
    logic         busy, done, alu_sel;
    logic [W-1:0] result_lo, result_hi;
    logic [W-1:0] alu_a, alu_b, alu_result;
    logic [3:0]   alu_control, alu_flags;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    alu_mul_sequencer #(.WIDTH(W), .CNT_W(5), .ALU_ADD(ALU_CTL_ADD)) dut (
        .clk(clk), .reset(reset), .start(start), .op_a(op_a), .op_b(op_b),
        .busy(busy), .done(done), .result_lo(result_lo), .result_hi(result_hi),
        .alu_sel(alu_sel), .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control),
        .alu_result(alu_result), .alu_flags(alu_flags)
    );

    // Behavioural shared ALU with flags {v,c,n,z}.
    logic [W:0] sum;
    always_comb begin
        case (alu_control)
            ALU_CTL_ADD: sum = {1'b0, alu_a} + {1'b0, alu_b};
            ALU_CTL_SUB: sum = {1'b0, alu_a} + {1'b0, ~alu_b} + 33'd1;
            ALU_CTL_AND: sum = {1'b0, alu_a & alu_b};
            ALU_CTL_OR:  sum = {1'b0, alu_a | alu_b};
            default:     sum = {1'b0, alu_a ^ alu_b};
        endcase
        alu_result = sum[W-1:0];
        alu_flags  = {(alu_a[W-1] == alu_b[W-1]) && (sum[W-1] != alu_a[W-1]),
                      sum[W], sum[W-1], (sum[W-1:0] == '0)};
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Starts one multiply and observes it. k counts edges after the accepting edge;
    // done must first appear at k == W. Returns -1 latency on timeout.
    task automatic run_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                           output logic [63:0] prod, output int lat,
                           output int busy_cyc, output int done_pulses);
        op_a = a; op_b = b; start = 1'b1;
        tick();
        start = 1'b0; op_a = $urandom; op_b = $urandom;
        lat = -1; busy_cyc = 0; done_pulses = 0; prod = '0;
        for (int k = 0; k < 100; k++) begin
            if (busy) busy_cyc++;
            if (done) begin
                done_pulses++;
                if (lat < 0) begin lat = k; prod = {result_hi, result_lo}; end
            end
            if (lat >= 0 && k >= lat + 2) break;
            tick();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; op_a = '0; op_b = '0;
        tick(); tick();
        n_tests++;
        if ({busy, done, alu_sel} !== 3'b000) begin
            n_fail++; $display("FAIL reset_status got %b exp 000", {busy, done, alu_sel});
        end
        n_tests++;
        if ({result_hi, result_lo} !== 64'd0) begin
            n_fail++; $display("FAIL reset_result got %h exp 0", {result_hi, result_lo});
        end
        n_tests++;
        if (alu_control !== ALU_CTL_ADD || alu_a !== '0 || alu_b !== '0) begin
            n_fail++; $display("FAIL reset_alu ctl %b a %h b %h exp 0000/0/0", alu_control, alu_a, alu_b);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_simple();
        logic [63:0] p; int lat, bc, dp;
        run_mul(32'd3, 32'd5, p, lat, bc, dp);
        n_tests++;
        if (p !== 64'd15) begin n_fail++; $display("FAIL simple_prod got %0d exp 15", p); end
        n_tests++;
        if (lat != W) begin n_fail++; $display("FAIL simple_latency got %0d exp %0d", lat, W); end
        n_tests++;
        if (bc != W) begin n_fail++; $display("FAIL simple_busy_cycles got %0d exp %0d", bc, W); end
        n_tests++;
        if (dp != 1) begin n_fail++; $display("FAIL simple_done_pulses got %0d exp 1", dp); end
        // Result must hold after DONE while idle.
        tick(); tick();
        n_tests++;
        if ({result_hi, result_lo} !== 64'd15 || done !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL simple_hold got %h done %b busy %b exp 15/0/0",
                               {result_hi, result_lo}, done, busy);
        end
    endtask

    task automatic test_corners();
        logic [63:0] p; int lat, bc, dp;
        run_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, p, lat, bc, dp);
        n_tests++;
        if (p[63:32] !== 32'hFFFF_FFFE || p[31:0] !== 32'h0000_0001) begin
            n_fail++; $display("FAIL max_carry got %h exp fffffffe00000001", p);
        end
        run_mul(32'd0, 32'h1234_5678, p, lat, bc, dp);
        n_tests++;
        if (p !== 64'd0) begin n_fail++; $display("FAIL zero_operand got %h exp 0", p); end
        run_mul(32'h8000_0000, 32'd2, p, lat, bc, dp);
        n_tests++;
        if (p !== 64'h0000_0001_0000_0000) begin
            n_fail++; $display("FAIL msb_shift got %h exp 0000000100000000", p);
        end
    endtask

    task automatic test_random();
        logic [63:0] p, expv; int lat, bc, dp;
        logic [W-1:0] a, b;
        for (int i = 0; i < 24; i++) begin
            a = $urandom; b = $urandom;
            if (i % 6 == 1) a = a | 32'hF000_0000;
            if (i % 6 == 2) b = 32'hFFFF_FFFF;
            expv = 64'(a) * 64'(b);
            run_mul(a, b, p, lat, bc, dp);
            n_tests++;
            if (p !== expv || lat != W || dp != 1) begin
                n_fail++; $display("FAIL random_%0d %h*%h got %h lat %0d dones %0d exp %h lat %0d dones 1",
                                   i, a, b, p, lat, dp, expv, W);
            end
        end
    endtask

    task automatic test_start_while_busy();
        int d1 = -1, dp = 0;
        logic [63:0] p = '0;
        op_a = 32'd3; op_b = 32'd5; start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 70; k++) begin
            if (done) begin
                dp++;
                if (d1 < 0) begin d1 = k; p = {result_hi, result_lo}; end
            end
            start = (k == 5 || k == 20);
            op_a = start ? 32'd7 : $urandom;
            op_b = start ? 32'd7 : $urandom;
            tick();
        end
        start = 1'b0;
        n_tests++;
        if (p !== 64'd15 || d1 != W) begin
            n_fail++; $display("FAIL busy_start_ignored got %0d at %0d exp 15 at %0d", p, d1, W);
        end
        n_tests++;
        if (dp != 1) begin n_fail++; $display("FAIL busy_start_done_count got %0d exp 1", dp); end
    endtask

    task automatic test_back_to_back();
        int d1 = -1, d2 = -1;
        logic [63:0] p1 = '0, p2 = '0;
        logic busy_after = 1'b0;
        op_a = 32'd3; op_b = 32'd5; start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 120; k++) begin
            if (d1 >= 0 && k == d1 + 1) busy_after = busy;
            start = 1'b0;
            if (done) begin
                if (d1 < 0) begin
                    d1 = k; p1 = {result_hi, result_lo};
                    start = 1'b1; op_a = 32'd10; op_b = 32'd20;
                end else if (d2 < 0) begin
                    d2 = k; p2 = {result_hi, result_lo};
                end
            end
            if (d2 >= 0) break;
            tick();
        end
        start = 1'b0;
        tick(); tick();
        n_tests++;
        if (p1 !== 64'd15) begin n_fail++; $display("FAIL b2b_first got %0d exp 15", p1); end
        n_tests++;
        if (p2 !== 64'd200) begin n_fail++; $display("FAIL b2b_second got %0d exp 200", p2); end
        n_tests++;
        if (d2 - d1 != W + 1 || busy_after !== 1'b1) begin
            n_fail++; $display("FAIL b2b_timing gap %0d busy %b exp %0d/1", d2 - d1, busy_after, W + 1);
        end
    endtask

    task automatic test_reset_mid();
        logic [63:0] p; int lat, bc, dp;
        op_a = $urandom | 32'h1; op_b = $urandom | 32'h1; start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 10; k++) tick();
        reset = 1'b1;
        tick();
        n_tests++;
        if ({busy, done, alu_sel} !== 3'b000 || {result_hi, result_lo} !== 64'd0) begin
            n_fail++; $display("FAIL reset_mid got busy %b done %b sel %b res %h exp 0/0/0/0",
                               busy, done, alu_sel, {result_hi, result_lo});
        end
        reset = 1'b0;
        tick();
        n_tests++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_mid_idle busy %b exp 0", busy); end
        run_mul(32'd6, 32'd7, p, lat, bc, dp);
        n_tests++;
        if (p !== 64'd42 || lat != W) begin
            n_fail++; $display("FAIL reset_mid_after got %0d lat %0d exp 42 lat %0d", p, lat, W);
        end
    endtask

    initial begin
        test_reset();
        test_simple();
        test_corners();
        test_random();
        test_start_while_busy();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
